// File: rtl/bbox_msg_reader_pkg.sv
// Shared definitions for the bounding-box message reader and the image
// processor register map it talks to.
package bbox_msg_reader_pkg;

  // Reader FSM states; *_RD are bus strobe cycles, *_WT the matching wait cycles.
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_STAT_RD,
    ST_STAT_WT,
    ST_BACKOFF,
    ST_ID_RD,
    ST_ID_WT,
    ST_TL_RD,
    ST_TL_WT,
    ST_BR_RD,
    ST_BR_WT,
    ST_PRESENT,
    ST_FLUSH,
    ST_FLUSH_WT
  } state_e;

  // Slave register map
  localparam logic [2:0]  ADDR_STATUS    = 3'd0;
  localparam logic [2:0]  ADDR_MSG       = 3'd1;
  localparam int          FLUSH_BIT      = 4;
  localparam logic [31:0] FLUSH_CMD      = 32'h1 << FLUSH_BIT;
  localparam logic [31:0] DEFAULT_MSG_ID = 32'h0052_4242;  // "RBB"

  // A message is ID + top-left + bottom-right; never start one unless all are queued.
  localparam logic [7:0]  MSG_WORDS      = 8'd3;

  // Horizontal centre of a box; the 12-bit sum cannot overflow.
  function automatic logic [10:0] box_centre(input logic [10:0] a, input logic [10:0] b);
    logic [11:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return 11'(sum >> 1);
  endfunction

endpackage

// File: rtl/bbox_msg_reader_mm_read_port.sv
// Avalon-MM access sequencer: one strobe cycle followed by one wait cycle in
// which the read data is valid. Requests arriving during the wait cycle are
// held off, so the slave never sees two strobes back to back.
module bbox_msg_reader_mm_read_port (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic        i_write,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_accept,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  logic r_wait;
  logic w_strobe;

  assign w_strobe     = i_req & ~r_wait;
  assign o_accept     = w_strobe;
  assign o_done       = r_wait;
  assign o_rdata      = m_readdata;

  // Strobes are decoded from the requester's state, so a reset drops them at once.
  assign m_chipselect = w_strobe;
  assign m_read       = w_strobe & ~i_write;
  assign m_write      = w_strobe & i_write;
  assign m_address    = w_strobe ? i_addr : 3'd0;
  assign m_writedata  = (w_strobe & i_write) ? i_wdata : 32'd0;

  // Track the wait cycle that follows every accepted strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wait <= 1'b0;
    end else begin
      r_wait <= w_strobe;
    end
  end

endmodule

// File: rtl/bbox_msg_reader.sv
// Drains "RBB" bounding-box messages from the image processor's message FIFO
// and presents them as a valid/ready box stream with delivery/error counters.
module bbox_msg_reader
  import bbox_msg_reader_pkg::*;
#(
  parameter int          POLL_INTERVAL = 1024,
  parameter logic [31:0] MSG_ID        = DEFAULT_MSG_ID,
  parameter logic [10:0] IMAGE_W       = 11'd640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        m_chipselect,
  output logic        m_read,
  output logic        m_write,
  output logic [2:0]  m_address,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata,
  output logic        box_valid,
  input  logic        box_ready,
  output logic [10:0] box_x_min,
  output logic [10:0] box_y_min,
  output logic [10:0] box_x_max,
  output logic [10:0] box_y_max,
  output logic [10:0] box_centre_x,
  output logic        box_empty,
  output logic [15:0] box_count,
  output logic [7:0]  err_count
);

  localparam int TIMER_W = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(POLL_INTERVAL - 1);

  state_e              r_state;
  state_e              w_state_next;
  logic [TIMER_W-1:0]  r_timer;

  logic                w_req;
  logic                w_write;
  logic [2:0]          w_addr;
  logic [31:0]         w_wdata;
  logic                w_accept;
  logic                w_done;
  logic [31:0]         w_rdata;

  logic                w_load_timer;
  logic                w_err_inc;
  logic                w_latch_tl;
  logic                w_latch_br;
  logic                w_present;

  logic [7:0]          w_size;
  logic [10:0]         w_word_x;
  logic [10:0]         w_word_y;
  logic                w_coord_err;

  logic [10:0]         r_tl_x;
  logic [10:0]         r_tl_y;
  logic [10:0]         r_br_x;
  logic [10:0]         r_br_y;

  logic                r_box_valid;
  logic [10:0]         r_box_x_min;
  logic [10:0]         r_box_y_min;
  logic [10:0]         r_box_x_max;
  logic [10:0]         r_box_y_max;
  logic [10:0]         r_box_centre_x;
  logic                r_box_empty;
  logic [15:0]         r_box_count;
  logic [7:0]          r_err_count;

  bbox_msg_reader_mm_read_port u_port (
    .clk          (clk),
    .reset        (reset),
    .i_req        (w_req),
    .i_write      (w_write),
    .i_addr       (w_addr),
    .i_wdata      (w_wdata),
    .o_accept     (w_accept),
    .o_done       (w_done),
    .o_rdata      (w_rdata),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata)
  );

  // Field views of the word returned by the current read.
  assign w_size      = w_rdata[15:8];
  assign w_word_x    = w_rdata[26:16];
  assign w_word_y    = w_rdata[10:0];
  assign w_coord_err = (r_tl_x >= IMAGE_W) || (w_word_x >= IMAGE_W);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and bus request decode. Dropping enable lets the access in
  // flight finish and then parks in IDLE; only a message whose last word has
  // already been read is carried through to completion.
  always_comb begin
    w_state_next = r_state;
    w_req        = 1'b0;
    w_write      = 1'b0;
    w_addr       = ADDR_STATUS;
    w_wdata      = 32'd0;
    w_load_timer = 1'b0;
    w_err_inc    = 1'b0;
    w_latch_tl   = 1'b0;
    w_latch_br   = 1'b0;
    w_present    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (enable && !r_box_valid) w_state_next = ST_STAT_RD;
      end
      ST_STAT_RD: begin
        w_req  = 1'b1;
        w_addr = ADDR_STATUS;
        if (w_accept) w_state_next = ST_STAT_WT;
      end
      ST_STAT_WT: begin
        if (w_done) begin
          if (!enable) begin
            w_state_next = ST_IDLE;
          end else if (w_size >= MSG_WORDS) begin
            w_state_next = ST_ID_RD;
          end else begin
            w_load_timer = 1'b1;
            w_state_next = ST_BACKOFF;
          end
        end
      end
      ST_BACKOFF: begin
        if (!enable || r_timer == '0) w_state_next = ST_IDLE;
      end
      ST_ID_RD: begin
        w_req  = 1'b1;
        w_addr = ADDR_MSG;
        if (w_accept) w_state_next = ST_ID_WT;
      end
      ST_ID_WT: begin
        if (w_done) begin
          if (!enable) begin
            w_state_next = ST_IDLE;
          end else if (w_rdata != MSG_ID) begin
            w_err_inc    = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            w_state_next = ST_TL_RD;
          end
        end
      end
      ST_TL_RD: begin
        w_req  = 1'b1;
        w_addr = ADDR_MSG;
        if (w_accept) w_state_next = ST_TL_WT;
      end
      ST_TL_WT: begin
        if (w_done) begin
          w_latch_tl   = 1'b1;
          w_state_next = enable ? ST_BR_RD : ST_IDLE;
        end
      end
      ST_BR_RD: begin
        w_req  = 1'b1;
        w_addr = ADDR_MSG;
        if (w_accept) w_state_next = ST_BR_WT;
      end
      ST_BR_WT: begin
        if (w_done) begin
          w_latch_br = 1'b1;
          if (w_coord_err) begin
            w_err_inc    = 1'b1;
            w_state_next = ST_FLUSH;
          end else begin
            w_state_next = ST_PRESENT;
          end
        end
      end
      ST_PRESENT: begin
        w_present    = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        w_req   = 1'b1;
        w_write = 1'b1;
        w_addr  = ADDR_STATUS;
        w_wdata = FLUSH_CMD;
        if (w_accept) w_state_next = ST_FLUSH_WT;
      end
      ST_FLUSH_WT: begin
        if (w_done) w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Poll back-off timer: loaded on an undersized STATUS, counts to zero in BACKOFF.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_timer <= '0;
    end else if (w_load_timer) begin
      r_timer <= TIMER_LOAD;
    end else if (r_state == ST_BACKOFF && r_timer != '0) begin
      r_timer <= r_timer - 1'b1;
    end
  end

  // Capture the two coordinate words as they arrive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_tl_x <= '0;
      r_tl_y <= '0;
      r_br_x <= '0;
      r_br_y <= '0;
    end else begin
      if (w_latch_tl) begin
        r_tl_x <= w_word_x;
        r_tl_y <= w_word_y;
      end
      if (w_latch_br) begin
        r_br_x <= w_word_x;
        r_br_y <= w_word_y;
      end
    end
  end

  // Output box register and handshake; fields only change when a new box is presented.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_box_valid    <= 1'b0;
      r_box_x_min    <= '0;
      r_box_y_min    <= '0;
      r_box_x_max    <= '0;
      r_box_y_max    <= '0;
      r_box_centre_x <= '0;
      r_box_empty    <= 1'b0;
      r_box_count    <= '0;
    end else if (w_present) begin
      r_box_valid    <= 1'b1;
      r_box_x_min    <= r_tl_x;
      r_box_y_min    <= r_tl_y;
      r_box_x_max    <= r_br_x;
      r_box_y_max    <= r_br_y;
      r_box_centre_x <= box_centre(r_tl_x, r_br_x);
      r_box_empty    <= (r_tl_x > r_br_x);
      r_box_count    <= r_box_count + 16'd1;
    end else if (r_box_valid && box_ready) begin
      r_box_valid    <= 1'b0;
    end
  end

  // Saturating decode-error counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_err_inc && r_err_count != 8'hFF) begin
      r_err_count <= r_err_count + 8'd1;
    end
  end

  assign box_valid    = r_box_valid;
  assign box_x_min    = r_box_x_min;
  assign box_y_min    = r_box_y_min;
  assign box_x_max    = r_box_x_max;
  assign box_y_max    = r_box_y_max;
  assign box_centre_x = r_box_centre_x;
  assign box_empty    = r_box_empty;
  assign box_count    = r_box_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_bbox_msg_reader.sv
// Bench for bbox_msg_reader: models the image-processor slave as a 256-deep
// word FIFO with registered read data and checks decoded boxes against a
// message-level reference model.
module tb_bbox_msg_reader;

  localparam int          P    = 32;
  localparam logic [31:0] RBB  = 32'h0052_4242;
  localparam int          IMGW = 640;

  typedef struct packed {
    logic [10:0] xmin;
    logic [10:0] ymin;
    logic [10:0] xmax;
    logic [10:0] ymax;
    logic [10:0] cx;
    logic        empty;
  } box_t;

  typedef struct packed {
    logic err;
    box_t box;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        enable;
  logic        m_chipselect, m_read, m_write;
  logic [2:0]  m_address;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;
  logic        box_valid, box_ready;
  logic [10:0] box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x;
  logic        box_empty;
  logic [15:0] box_count;
  logic [7:0]  err_count;

  int vectors    = 0;
  int miscompares = 0;

  bbox_msg_reader #(.POLL_INTERVAL(P), .MSG_ID(RBB), .IMAGE_W(11'd640)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .m_chipselect (m_chipselect),
    .m_read       (m_read),
    .m_write      (m_write),
    .m_address    (m_address),
    .m_writedata  (m_writedata),
    .m_readdata   (m_readdata),
    .box_valid    (box_valid),
    .box_ready    (box_ready),
    .box_x_min    (box_x_min),
    .box_y_min    (box_y_min),
    .box_x_max    (box_x_max),
    .box_y_max    (box_y_max),
    .box_centre_x (box_centre_x),
    .box_empty    (box_empty),
    .box_count    (box_count),
    .err_count    (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- slave model and bus monitor ----------------
  logic [31:0] mem [0:255];
  int          wr_ptr = 0;          // written by stimulus only
  int          rd_ptr = 0;          // written by the slave only
  logic [31:0] rdata_reg = 32'd0;
  int cyc = 0, stat_reads = 0, msg_reads = 0, writes = 0, b2b = 0;
  int stat_cyc = 0, stat_prev_cyc = 0, valid_cyc = 0, valid_rises = 0;
  int snap_stat = 0, snap_msg = 0, snap_stat_cyc = 0;
  logic [31:0] last_wdata = 32'd0;
  logic [2:0]  last_waddr = 3'd0;
  logic        prev_strobe = 1'b0, prev_valid = 1'b0;
  box_t        got_mem [0:511];
  int          got_n = 0;
  logic [118:0] all_outs;

  assign m_readdata = rdata_reg;
  assign all_outs = {m_chipselect, m_read, m_write, m_address, m_writedata, box_valid,
                     box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x, box_empty,
                     box_count, err_count};

  always @(posedge clk) begin
    cyc <= cyc + 1;
    prev_strobe <= m_chipselect & (m_read | m_write);
    if (m_chipselect && (m_read || m_write) && prev_strobe) b2b <= b2b + 1;
    if (m_chipselect && m_read) begin
      if (m_address == 3'd0) begin
        rdata_reg     <= {16'h0, 8'(wr_ptr - rd_ptr), 8'h0};
        stat_reads    <= stat_reads + 1;
        stat_prev_cyc <= stat_cyc;
        stat_cyc      <= cyc;
      end else begin
        msg_reads <= msg_reads + 1;
        if (wr_ptr != rd_ptr) begin
          rdata_reg <= mem[rd_ptr[7:0]];
          rd_ptr    <= rd_ptr + 1;
        end else begin
          rdata_reg <= 32'd0;
        end
      end
    end
    if (m_chipselect && m_write) begin
      writes     <= writes + 1;
      last_wdata <= m_writedata;
      last_waddr <= m_address;
      if (m_address == 3'd0 && m_writedata[4]) rd_ptr <= wr_ptr;
    end
    prev_valid <= box_valid;
    if (box_valid && !prev_valid) begin
      valid_rises   <= valid_rises + 1;
      valid_cyc     <= cyc;
      snap_stat     <= stat_reads;
      snap_msg      <= msg_reads;
      snap_stat_cyc <= stat_cyc;
    end
    if (box_valid && box_ready) begin
      got_mem[got_n[8:0]] <= {box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x, box_empty};
      got_n <= got_n + 1;
    end
  end

  // ---------------- reference model and stimulus helpers ----------------
  function automatic logic [31:0] coord(input int x, input int y);
    logic [10:0] xv, yv;
    xv = 11'(x);
    yv = 11'(y);
    return {5'd0, xv, 5'd0, yv};
  endfunction

  // Message-level meaning of an ID/top-left/bottom-right word triple.
  function automatic exp_t model_msg(input logic [31:0] id, input logic [31:0] tl, input logic [31:0] br);
    exp_t e;
    int xmin, ymin, xmax, ymax;
    xmin = int'((tl >> 16) & 32'h7FF);
    ymin = int'(tl & 32'h7FF);
    xmax = int'((br >> 16) & 32'h7FF);
    ymax = int'(br & 32'h7FF);
    e.err       = (id != RBB) || (xmin >= IMGW) || (xmax >= IMGW);
    e.box.xmin  = 11'(xmin);
    e.box.ymin  = 11'(ymin);
    e.box.xmax  = 11'(xmax);
    e.box.ymax  = 11'(ymax);
    e.box.cx    = 11'((xmin + xmax) / 2);
    e.box.empty = (xmin > xmax);
    return e;
  endfunction

  task automatic push(input logic [31:0] w);
    mem[wr_ptr[7:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic push_msg(input logic [31:0] id, input logic [31:0] tl, input logic [31:0] br);
    push(id);
    push(tl);
    push(br);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_assert();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
  endtask

  task automatic reset_release();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (box_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_msg_reads(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      if (msg_reads >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    box_ready = 1'b1;
    cycles(3);
    vectors++;
    if (all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h required 0", all_outs);
    end
    $display("reset: outputs checked while reset held");
  endtask

  task automatic test_single_box();
    exp_t e;
    bit ok;
    int b_stat, b_msg, b_got;
    e = model_msg(RBB, coord(100, 50), coord(300, 200));
    push_msg(RBB, coord(100, 50), coord(300, 200));
    b_stat = stat_reads; b_msg = msg_reads; b_got = got_n;
    reset_release();
    wait_valid(40, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL single_timeout: got no box_valid required box_valid within 40 cycles");
    end
    cycles(2);
    vectors++;
    if (got_n - b_got !== 1) begin
      miscompares++;
      $display("FAIL single_box_n: got %0d required 1", got_n - b_got);
    end
    vectors++;
    if (got_mem[b_got] !== e.box) begin
      miscompares++;
      $display("FAIL single_box: got %h required %h", got_mem[b_got], e.box);
    end
    vectors++;
    if (box_count !== 16'd1) begin
      miscompares++;
      $display("FAIL single_count: got %0d required 1", box_count);
    end
    vectors++;
    if (snap_stat - b_stat !== 1 || snap_msg - b_msg !== 3) begin
      miscompares++;
      $display("FAIL single_reads: got stat=%0d msg=%0d required stat=1 msg=3",
               snap_stat - b_stat, snap_msg - b_msg);
    end
    vectors++;
    if (valid_cyc - snap_stat_cyc !== 9) begin
      miscompares++;
      $display("FAIL single_latency: got %0d required 9", valid_cyc - snap_stat_cyc);
    end
    $display("single: box %0d/%0d/%0d/%0d centre %0d", box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x);
  endtask

  task automatic test_backoff();
    exp_t e;
    bit ok;
    int b_msg, b_got;
    reset_assert();
    reset_release();
    e = model_msg(RBB, coord(10, 20), coord(30, 40));
    push(RBB);
    push(coord(10, 20));
    b_msg = msg_reads; b_got = got_n;
    cycles(4 * (P + 3) + 10);
    vectors++;
    if (msg_reads - b_msg !== 0) begin
      miscompares++;
      $display("FAIL backoff_no_msg: got %0d msg reads required 0", msg_reads - b_msg);
    end
    // IDLE + STAT_RD + STAT_WT + POLL_INTERVAL backoff cycles between strobes.
    vectors++;
    if (stat_cyc - stat_prev_cyc !== P + 3) begin
      miscompares++;
      $display("FAIL backoff_spacing: got %0d required %0d", stat_cyc - stat_prev_cyc, P + 3);
    end
    push(coord(30, 40));
    wait_valid(P + 20, ok);
    cycles(2);
    vectors++;
    if (!ok || got_n - b_got !== 1 || got_mem[b_got] !== e.box || msg_reads - b_msg !== 3) begin
      miscompares++;
      $display("FAIL backoff_box: got ok=%0d n=%0d box=%h msg=%0d required ok=1 n=1 box=%h msg=3",
               ok, got_n - b_got, got_mem[b_got], msg_reads - b_msg, e.box);
    end
    $display("backoff: poll spacing %0d cycles", stat_cyc - stat_prev_cyc);
  endtask

  task automatic test_bad_id();
    int b_msg, b_wr, b_rise;
    reset_assert();
    push_msg(32'hDEADBEEF, coord(1, 2), coord(3, 4));
    b_msg = msg_reads; b_wr = writes; b_rise = valid_rises;
    reset_release();
    cycles(60);
    vectors++;
    if (err_count !== 8'd1) begin
      miscompares++;
      $display("FAIL bad_id_err: got %0d required 1", err_count);
    end
    vectors++;
    if (writes - b_wr !== 1 || last_wdata !== 32'h10 || last_waddr !== 3'd0) begin
      miscompares++;
      $display("FAIL bad_id_flush: got n=%0d addr=%0d data=%h required n=1 addr=0 data=00000010",
               writes - b_wr, last_waddr, last_wdata);
    end
    vectors++;
    if (valid_rises - b_rise !== 0 || msg_reads - b_msg !== 1 || wr_ptr !== rd_ptr) begin
      miscompares++;
      $display("FAIL bad_id_side: got boxes=%0d msg=%0d left=%0d required 0/1/0",
               valid_rises - b_rise, msg_reads - b_msg, wr_ptr - rd_ptr);
    end
    $display("bad_id: err_count %0d", err_count);
  endtask

  task automatic test_empty_frame();
    exp_t e;
    int b_got;
    reset_assert();
    e = model_msg(RBB, coord(639, 479), coord(0, 0));
    push_msg(RBB, coord(639, 479), coord(0, 0));
    b_got = got_n;
    reset_release();
    cycles(40);
    vectors++;
    if (got_n - b_got !== 1 || got_mem[b_got] !== e.box) begin
      miscompares++;
      $display("FAIL empty_frame: got n=%0d box=%h required n=1 box=%h", got_n - b_got, got_mem[b_got], e.box);
    end
    vectors++;
    if (got_mem[b_got].empty !== 1'b1 || got_mem[b_got].cx !== 11'd319) begin
      miscompares++;
      $display("FAIL empty_flags: got empty=%0d cx=%0d required empty=1 cx=319",
               got_mem[b_got].empty, got_mem[b_got].cx);
    end
    $display("empty_frame: centre %0d empty %0d", got_mem[b_got].cx, got_mem[b_got].empty);
  endtask

  task automatic test_backpressure();
    exp_t e0, e1;
    logic [31:0] t0, b0, t1, b1;
    logic [55:0] held;
    bit ok;
    int b_msg, b_got;
    reset_assert();
    box_ready = 1'b0;
    t0 = coord(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    b0 = coord(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    t1 = coord(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    b1 = coord(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)));
    e0 = model_msg(RBB, t0, b0);
    e1 = model_msg(RBB, t1, b1);
    push_msg(RBB, t0, b0);
    push_msg(RBB, t1, b1);
    b_msg = msg_reads; b_got = got_n;
    reset_release();
    wait_valid(40, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_timeout: got no box_valid required box_valid within 40 cycles");
    end
    held = {box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x, box_empty};
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      vectors++;
      if (box_valid !== 1'b1 || {box_x_min, box_y_min, box_x_max, box_y_max, box_centre_x, box_empty} !== held
          || msg_reads - b_msg !== 3) begin
        miscompares++;
        $display("FAIL bp_hold: cycle %0d got valid=%0d msg=%0d required valid=1 msg=3 box stable",
                 i, box_valid, msg_reads - b_msg);
      end
    end
    box_ready = 1'b1;
    cycles(40);
    vectors++;
    if (got_n - b_got !== 2 || got_mem[b_got] !== e0.box || got_mem[b_got + 1] !== e1.box) begin
      miscompares++;
      $display("FAIL bp_boxes: got n=%0d %h %h required n=2 %h %h",
               got_n - b_got, got_mem[b_got], got_mem[b_got + 1], e0.box, e1.box);
    end
    vectors++;
    if (box_count !== 16'd2) begin
      miscompares++;
      $display("FAIL bp_count: got %0d required 2", box_count);
    end
    $display("backpressure: %0d boxes after release", got_n - b_got);
  endtask

  task automatic test_enable_drop();
    bit ok;
    int b_msg, b_wr, b_got;
    reset_assert();
    push_msg(RBB, coord(5, 6), coord(7, 8));
    push_msg(RBB, coord(9, 10), coord(11, 12));
    b_msg = msg_reads; b_wr = writes; b_got = got_n;
    reset_release();
    wait_msg_reads(b_msg + 1, 40, ok);
    enable = 1'b0;
    cycles(20);
    vectors++;
    if (!ok || msg_reads - b_msg !== 1 || writes - b_wr !== 0) begin
      miscompares++;
      $display("FAIL en_drop_park: got ok=%0d msg=%0d wr=%0d required ok=1 msg=1 wr=0",
               ok, msg_reads - b_msg, writes - b_wr);
    end
    @(negedge clk);
    enable = 1'b1;
    cycles(P + 40);
    vectors++;
    if (err_count !== 8'd1 || writes - b_wr !== 1 || got_n - b_got !== 0 || wr_ptr !== rd_ptr) begin
      miscompares++;
      $display("FAIL en_drop_resync: got err=%0d wr=%0d boxes=%0d left=%0d required 1/1/0/0",
               err_count, writes - b_wr, got_n - b_got, wr_ptr - rd_ptr);
    end
    $display("enable_drop: partial message flushed, err_count %0d", err_count);
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b_msg, b_wr, b_got;
    reset_assert();
    push_msg(RBB, coord(300, 10), coord(310, 20));
    push_msg(RBB, coord(320, 30), coord(330, 40));
    b_msg = msg_reads; b_got = got_n;
    reset_release();
    wait_msg_reads(b_msg + 2, 40, ok);
    reset = 1'b1;
    #1;
    vectors++;
    if (!ok || all_outs !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got ok=%0d outs=%h required ok=1 outs=0", ok, all_outs);
    end
    b_wr = writes;
    cycles(2);
    reset_release();
    cycles(P + 40);
    vectors++;
    if (err_count !== 8'd1 || writes - b_wr !== 1 || got_n - b_got !== 0 || wr_ptr !== rd_ptr) begin
      miscompares++;
      $display("FAIL reset_mid_flush: got err=%0d wr=%0d boxes=%0d left=%0d required 1/1/0/0",
               err_count, writes - b_wr, got_n - b_got, wr_ptr - rd_ptr);
    end
    $display("reset_mid: leftover words flushed");
  endtask

  task automatic test_random();
    exp_t e;
    logic [31:0] id, tl, br;
    int exp_err, exp_box, b_got;
    reset_assert();
    reset_release();
    exp_err = 0; exp_box = 0; b_got = got_n;
    for (int k = 0; k < 12; k++) begin
      id = ($urandom_range(0, 5) == 0) ? $urandom : RBB;
      tl = coord(int'($urandom_range(0, 700)), int'($urandom_range(0, 479)));
      br = coord(int'($urandom_range(0, 700)), int'($urandom_range(0, 479)));
      e = model_msg(id, tl, br);
      push_msg(id, tl, br);
      cycles(P + 30);
      if (e.err) exp_err++;
      else exp_box++;
      vectors++;
      if (err_count !== 8'(exp_err) || box_count !== 16'(exp_box) || got_n - b_got !== exp_box
          || (!e.err && got_mem[got_n - 1] !== e.box)) begin
        miscompares++;
        $display("FAIL random_%0d: got err=%0d boxes=%0d last=%h required err=%0d boxes=%0d last=%h",
                 k, err_count, box_count, got_mem[got_n - 1], exp_err, exp_box, e.box);
      end
      $display("random %0d: id=%h tl=%h br=%h -> %s", k, id, tl, br, e.err ? "error" : "box");
    end
  endtask

  task automatic test_err_saturate();
    reset_assert();
    reset_release();
    for (int k = 0; k < 260; k++) begin
      push_msg(32'hDEADBEEF, $urandom, $urandom);
      cycles(P + 25);
    end
    vectors++;
    if (err_count !== 8'hFF) begin
      miscompares++;
      $display("FAIL err_saturate: got %0d required 255", err_count);
    end
    vectors++;
    if (b2b !== 0) begin
      miscompares++;
      $display("FAIL back_to_back_strobes: got %0d required 0", b2b);
    end
    $display("err_saturate: err_count %0d after 260 bad messages", err_count);
  endtask

  initial begin
    test_reset();
    test_single_box();
    test_backoff();
    test_bad_id();
    test_empty_frame();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_random();
    test_err_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
